scan_mux_inverter: RTL and testbench

- Parametrised N-channel, W-bit selector with an optional bitwise-invert mode and one registered valid/ready output stage.
- Generalises the 2:1 mux / mux-as-inverter primitives to many channels and many bits.
- Channel choice comes from an external select (FIXED mode) or from an internal round-robin scan pointer (SCAN mode).
- Sits between several producer streams and a single consumer in the homework datapath examples.

---
 rtl/scan_mux_pkg.sv | 11 +
 rtl/mux_n.sv | 22 ++
 rtl/scan_mux_inverter.sv | 82 ++++++++
 tb/tb_scan_mux_inverter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan/fixed channel selector.
package scan_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_SCAN  = 1'b1
    } mode_t;

    localparam int XFER_CNT_W = 16;

endpackage

// File: rtl/mux_n.sv
// Combinational N:1 word selector; zero is returned for an out-of-range index.
// No latency, no flow control.
module mux_n #(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] data,
    input  logic [CW-1:0]     idx,
    output logic [W-1:0]      q
);

    always_comb begin
        q = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (idx == CW'(c)) begin
                q = data[c*W +: W];
            end
        end
    end

endmodule

// File: rtl/scan_mux_inverter.sv
// N-channel selector (fixed select or round-robin scan) with optional invert, 1-cycle registered output.
// Output word holds under backpressure; a single ready is granted only to the active channel.
module scan_mux_inverter
    import scan_mux_pkg::*;
#(
    parameter  int N_CH = 4,
    parameter  int W    = 8,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH*W-1:0]     in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  mode,
    input  logic [CW-1:0]         sel,
    input  logic                  invert,
    output logic [W-1:0]          out_data,
    output logic [CW-1:0]         out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    localparam logic [CW-1:0] PTR_LAST = CW'(N_CH - 1);

    mode_t          mode_e;
    logic [CW-1:0]  ptr;
    logic [CW-1:0]  act;
    logic           can_load;
    logic           xfer;
    logic [W-1:0]   act_data;

    assign mode_e   = mode_t'(mode);
    assign act      = (mode_e == MODE_SCAN) ? ptr : sel;
    assign can_load = !out_valid || out_ready;

    // An act beyond N_CH-1 matches no channel, so no ready is raised and nothing loads.
    always_comb begin
        in_ready = '0;
        for (int c = 0; c < N_CH; c++) begin
            in_ready[c] = can_load && (act == CW'(c));
        end
    end

    assign xfer = |(in_valid & in_ready);

    mux_n #(
        .N_CH (N_CH),
        .W    (W)
    ) u_mux (
        .data (in_data),
        .idx  (act),
        .q    (act_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            xfer_cnt  <= '0;
            ptr       <= '0;
        end else begin
            if (can_load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= invert ? ~act_data : act_data;
                    out_ch   <= act;
                end
                // Scan steps every loadable cycle so idle channels cost one clock each.
                if (mode_e == MODE_SCAN) begin
                    ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
                end
            end
            if (xfer) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_mux_inverter.sv
// Directed bench for scan_mux_inverter: scoreboard of expected words checked by an output monitor.
module tb_scan_mux_inverter;

    typedef struct packed {
        logic [7:0]  data;
        logic [1:0]  ch;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Main DUT, N_CH=4
    logic [7:0]  d [4];
    logic [31:0] in_data;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic        mode = 1'b0;
    logic [1:0]  sel = '0;
    logic        invert = 1'b0;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] xfer_cnt;

    // Second DUT, N_CH=3 (non power of two)
    logic [23:0] in_data3 = {8'd2, 8'd1, 8'd0};
    logic [2:0]  in_valid3 = '0;
    logic [2:0]  in_ready3;
    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic [15:0] xfer_cnt3;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb [$];
    logic [15:0] exp_cnt = '0;

    assign in_data = {d[3], d[2], d[1], d[0]};

    always #5 clk = ~clk;

    scan_mux_inverter #(.N_CH(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .invert    (invert),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    scan_mux_inverter #(.N_CH(3), .W(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .invert    (1'b0),
        .out_data  (out_data3),
        .out_ch    (out_ch3),
        .out_valid (out_valid3),
        .out_ready (1'b1),
        .xfer_cnt  (xfer_cnt3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] data, input logic [1:0] ch);
        exp_cnt = exp_cnt + 16'd1;
        sb.push_back('{data: data, ch: ch, cnt: exp_cnt});
    endtask

    // Monitor: pops on every output handshake and checks held words stay stable while stalled.
    initial begin
        logic       stalled;
        logic [7:0] held_data;
        logic [1:0] held_ch;
        exp_t       e;
        stalled = 1'b0;
        held_data = '0;
        held_ch = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'(held_data));
                    check("hold_ch", 32'(out_ch), 32'(held_ch));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("sb_data", 32'(out_data), 32'(e.data));
                        check("sb_ch", 32'(out_ch), 32'(e.ch));
                        check("sb_cnt", 32'(xfer_cnt), 32'(e.cnt));
                    end
                end
                stalled   = out_valid && !out_ready;
                held_data = out_data;
                held_ch   = out_ch;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] wd;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;

        // Reset with every channel valid
        in_valid = 4'hF;
        cyc();
        cyc();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_ch", 32'(out_ch), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        rst = 1'b0;
        in_valid = 4'h0;

        // N_CH=3 scan visits 0,1,2,0,1,2
        mode3 = 1'b1;
        in_valid3 = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cyc();
            check("n3_valid", 32'(out_valid3), 32'd1);
            check("n3_ch", 32'(out_ch3), 32'(k % 3));
            check("n3_data", 32'(out_data3), 32'(k % 3));
        end
        mode3 = 1'b0;
        sel3 = 2'd3;
        #1;
        check("n3_oor_ready", 32'(in_ready3), 32'd0);
        cyc();
        check("n3_oor_nocap", 32'(out_valid3), 32'd0);
        in_valid3 = '0;

        // FIXED, no invert
        sel = 2'd2;
        d[2] = 8'hA5;
        in_valid = 4'b0100;
        #1;
        check("fixed_ready", 32'(in_ready), 32'b0100);
        expect_word(8'hA5, 2'd2);
        cyc();
        in_valid = 4'b0000;
        cyc();

        // FIXED with invert, then stall while toggling invert/sel
        sel = 2'd1;
        invert = 1'b1;
        d[1] = 8'h3C;
        in_valid = 4'b0010;
        expect_word(8'hC3, 2'd1);
        cyc();
        out_ready = 1'b0;
        in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            invert = ~invert;
            sel = 2'(k);
            #1;
            check("stall_ready", 32'(in_ready), 32'd0);
            check("stall_data", 32'(out_data), 32'hC3);
            cyc();
        end
        in_valid = 4'h0;
        invert = 1'b0;
        out_ready = 1'b1;
        cyc();
        cyc();

        // SCAN skip and wrap: ch0 and ch3 valid
        mode = 1'b1;
        d[0] = 8'h11;
        d[3] = 8'h33;
        in_valid = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            if (k % 4 == 0) expect_word(8'h11, 2'd0);
            if (k % 4 == 3) expect_word(8'h33, 2'd3);
            cyc();
        end

        // SCAN backpressure while pointer sits on ch1
        d[0] = 8'h0F;
        d[1] = 8'h5A;
        in_valid = 4'b0011;
        expect_word(8'h0F, 2'd0);
        cyc();
        out_ready = 1'b0;
        #1;
        check("bp_ready0", 32'(in_ready), 32'd0);
        cyc();
        check("bp_ready1", 32'(in_ready), 32'd0);
        cyc();
        out_ready = 1'b1;
        #1;
        check("bp_ptr_held", 32'(in_ready), 32'b0010);
        expect_word(8'h5A, 2'd1);
        cyc();
        in_valid = 4'h0;
        cyc();
        cyc();
        check("bp_cnt", 32'(xfer_cnt), 32'd8);

        // Mode switch takes effect on act in the same cycle
        mode = 1'b0;
        sel = 2'd3;
        #1;
        check("sw_fixed_ready", 32'(in_ready), 32'b1000);
        mode = 1'b1;
        #1;
        check("sw_scan_ready", 32'(in_ready), 32'b0001);

        // Counter wrap, back-to-back transfers with alternating invert
        mode = 1'b0;
        sel = 2'd0;
        in_valid = 4'b0001;
        while (exp_cnt != 16'hFFFF) begin
            wd = exp_cnt[7:0];
            invert = exp_cnt[0];
            d[0] = wd;
            expect_word(invert ? ~wd : wd, 2'd0);
            cyc();
        end
        check("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
        invert = 1'b0;
        d[0] = 8'h5C;
        expect_word(8'h5C, 2'd0);
        cyc();
        in_valid = 4'h0;
        check("cnt_wrap", 32'(xfer_cnt), 32'd0);
        cyc();

        // Reset while a word is held under backpressure
        mode = 1'b1;
        cyc();
        mode = 1'b0;
        sel = 2'd2;
        d[2] = 8'h77;
        in_valid = 4'b0100;
        cyc();
        out_ready = 1'b0;
        in_valid = 4'h0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_cnt = '0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cnt", 32'(xfer_cnt), 32'd0);
        mode = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid_rst_ptr", 32'(in_ready), 32'b0001);
        d[0] = 8'h99;
        in_valid = 4'b0001;
        expect_word(8'h99, 2'd0);
        cyc();
        in_valid = 4'h0;
        cyc();
        cyc();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
